// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage.
//   FWD_*      : forwarding-select encodings driven by the hazard unit
//   wd_state_e : stall watchdog states
//   REG_ZERO   : architectural $0 index (always reads as zero)
package id_ex_operand_stage_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_ERROR = 2'd2
    } wd_state_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_operand_mux.sv
// Forwarding operand select for one source operand.
//   sel      : forwarding select (RF / EX / MEM / WB)
//   reg_idx  : source register index; index 0 forces a zero operand
//   rf_data, ex_data, mem_data, wb_data : candidate values
//   operand  : selected operand (combinational)
module id_ex_operand_stage_fwd_operand_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [4:0]        reg_idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = rf_data;
        case (sel)
            FWD_EX:  operand = ex_data;
            FWD_MEM: operand = mem_data;
            FWD_WB:  operand = wb_data;
            default: operand = rf_data;
        endcase
        // $0 must read as zero even if a stale forward targets it.
        if (reg_idx == REG_ZERO) begin
            operand = '0;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, bubble insertion,
// downstream hold, performance counters and a runaway-stall watchdog.
//   Inputs : ID operands/indices/control, forwarding buses, pa/pb selectors,
//            nop_signal (bubble), hold (freeze)
//   Outputs: registered ex_* operands/control/flags, saturating
//            stall/forward counters, sticky stall_error
//
// Watchdog states:
//   state    | meaning
//   ST_RUN   | instructions flowing, no bubble in progress
//   ST_STALL | run_len consecutive bubbles so far, within tolerance
//   ST_ERROR | bubble run exceeded MAX_STALL; sticky until reset
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 16,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] id_pa,
    input  logic [DATA_W-1:0] id_pb,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [1:0]        pa_selector,
    input  logic [1:0]        pb_selector,
    input  logic              nop_signal,
    input  logic              hold,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_dest,
    input  logic              id_rf_enable,
    input  logic              id_load_instruction,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_destination,
    output logic              ex_rf_enable,
    output logic              ex_load_instruction,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  fwd_a_count,
    output logic [CNT_W-1:0]  fwd_b_count,
    output logic              stall_error
);

    // run_len must hold MAX_STALL+1, the value that trips the watchdog.
    localparam int               RUN_W     = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [DATA_W-1:0] sel_a, sel_b;

    id_ex_operand_stage_fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_a (
        .sel      (pa_selector),
        .reg_idx  (id_rs),
        .rf_data  (id_pa),
        .ex_data  (ex_result),
        .mem_data (mem_result),
        .wb_data  (wb_result),
        .operand  (sel_a)
    );

    id_ex_operand_stage_fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_b (
        .sel      (pb_selector),
        .reg_idx  (id_rt),
        .rf_data  (id_pb),
        .ex_data  (ex_result),
        .mem_data (mem_result),
        .wb_data  (wb_result),
        .operand  (sel_b)
    );

    // hold outranks nop_signal: a frozen stage records no bubble.
    logic do_bubble, do_load;
    assign do_bubble = !hold && nop_signal;
    assign do_load   = !hold && !nop_signal;

    logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [4:0]        ex_dest_q, ex_dest_d;
    logic              ex_rf_en_q, ex_rf_en_d, ex_load_q, ex_load_d, ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  fwd_a_count_q, fwd_a_count_d, fwd_b_count_q, fwd_b_count_d;
    wd_state_e         state_q, state_d;
    logic [RUN_W-1:0]  run_len_q, run_len_d;

    always_comb begin
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_dest_d  = ex_dest_q;
        ex_rf_en_d = ex_rf_en_q;
        ex_load_d  = ex_load_q;
        ex_valid_d = ex_valid_q;
        if (do_bubble) begin
            ex_a_d     = '0;
            ex_b_d     = '0;
            ex_ctrl_d  = '0;
            ex_dest_d  = '0;
            ex_rf_en_d = 1'b0;
            ex_load_d  = 1'b0;
            ex_valid_d = 1'b0;
        end else if (do_load) begin
            ex_a_d     = sel_a;
            ex_b_d     = sel_b;
            ex_ctrl_d  = id_ctrl;
            ex_dest_d  = id_dest;
            ex_rf_en_d = id_rf_enable;
            ex_load_d  = id_load_instruction;
            ex_valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        fwd_a_count_d = fwd_a_count_q;
        fwd_b_count_d = fwd_b_count_q;
        if (do_bubble && stall_count_q != '1) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
        // Forwards into $0 are discarded by the mux, so they are not counted.
        if (do_load && pa_selector != FWD_RF && id_rs != REG_ZERO && fwd_a_count_q != '1) begin
            fwd_a_count_d = fwd_a_count_q + CNT_ONE;
        end
        if (do_load && pb_selector != FWD_RF && id_rt != REG_ZERO && fwd_b_count_q != '1) begin
            fwd_b_count_d = fwd_b_count_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        case (state_q)
            ST_RUN: begin
                if (do_bubble) begin
                    state_d   = ST_STALL;
                    run_len_d = RUN_ONE;
                end
            end
            ST_STALL: begin
                if (do_bubble) begin
                    run_len_d = run_len_q + RUN_ONE;
                    if (run_len_q >= RUN_LIMIT) begin
                        state_d = ST_ERROR;
                    end
                end else if (do_load) begin
                    state_d   = ST_RUN;
                    run_len_d = '0;
                end
            end
            ST_ERROR: begin
                if (do_load) begin
                    run_len_d = '0;
                end else if (do_bubble && run_len_q <= RUN_LIMIT) begin
                    run_len_d = run_len_q + RUN_ONE;
                end
            end
            default: begin
                state_d   = ST_RUN;
                run_len_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_ctrl_q     <= '0;
            ex_dest_q     <= '0;
            ex_rf_en_q    <= 1'b0;
            ex_load_q     <= 1'b0;
            ex_valid_q    <= 1'b0;
            stall_count_q <= '0;
            fwd_a_count_q <= '0;
            fwd_b_count_q <= '0;
            state_q       <= ST_RUN;
            run_len_q     <= '0;
        end else begin
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_dest_q     <= ex_dest_d;
            ex_rf_en_q    <= ex_rf_en_d;
            ex_load_q     <= ex_load_d;
            ex_valid_q    <= ex_valid_d;
            stall_count_q <= stall_count_d;
            fwd_a_count_q <= fwd_a_count_d;
            fwd_b_count_q <= fwd_b_count_d;
            state_q       <= state_d;
            run_len_q     <= run_len_d;
        end
    end

    assign ex_a                = ex_a_q;
    assign ex_b                = ex_b_q;
    assign ex_ctrl             = ex_ctrl_q;
    assign ex_destination      = ex_dest_q;
    assign ex_rf_enable        = ex_rf_en_q;
    assign ex_load_instruction = ex_load_q;
    assign ex_valid            = ex_valid_q;
    assign stall_count         = stall_count_q;
    assign fwd_a_count         = fwd_a_count_q;
    assign fwd_b_count         = fwd_b_count_q;
    assign stall_error         = (state_q == ST_ERROR);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage. The driver applies inputs just
// after each falling edge and queues the expected post-edge outputs from a
// behavioural model; the monitor pops and compares shortly after each rising
// edge. Counters are narrowed to 4 bits so saturation is reachable.
module tb_id_ex_operand_stage;

    localparam int DATA_W    = 32;
    localparam int CTRL_W    = 16;
    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] id_pa, id_pb, ex_result, mem_result, wb_result;
    logic [4:0]        id_rs, id_rt, id_dest;
    logic [1:0]        pa_selector, pb_selector;
    logic              nop_signal, hold, id_rf_enable, id_load_instruction;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_destination;
    logic              ex_rf_enable, ex_load_instruction, ex_valid, stall_error;
    logic [CNT_W-1:0]  stall_count, fwd_a_count, fwd_b_count;

    always #5 clk = ~clk;

    id_ex_operand_stage #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .id_pa(id_pa), .id_pb(id_pb), .id_rs(id_rs), .id_rt(id_rt),
        .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
        .pa_selector(pa_selector), .pb_selector(pb_selector),
        .nop_signal(nop_signal), .hold(hold),
        .id_ctrl(id_ctrl), .id_dest(id_dest),
        .id_rf_enable(id_rf_enable), .id_load_instruction(id_load_instruction),
        .ex_a(ex_a), .ex_b(ex_b), .ex_ctrl(ex_ctrl), .ex_destination(ex_destination),
        .ex_rf_enable(ex_rf_enable), .ex_load_instruction(ex_load_instruction),
        .ex_valid(ex_valid),
        .stall_count(stall_count), .fwd_a_count(fwd_a_count), .fwd_b_count(fwd_b_count),
        .stall_error(stall_error)
    );

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        dest;
        logic              rf;
        logic              ld;
        logic              vld;
        int                stall;
        int                fa;
        int                fb;
        logic              err;
    } exp_t;

    exp_t sbq[$];
    exp_t m;
    int   streak;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input exp_t e, input string tag);
        chk({tag, " ex_a"}, 64'(ex_a), 64'(e.a));
        chk({tag, " ex_b"}, 64'(ex_b), 64'(e.b));
        chk({tag, " ex_ctrl"}, 64'(ex_ctrl), 64'(e.ctrl));
        chk({tag, " ex_destination"}, 64'(ex_destination), 64'(e.dest));
        chk({tag, " ex_rf_enable"}, 64'(ex_rf_enable), 64'(e.rf));
        chk({tag, " ex_load_instruction"}, 64'(ex_load_instruction), 64'(e.ld));
        chk({tag, " ex_valid"}, 64'(ex_valid), 64'(e.vld));
        chk({tag, " stall_count"}, 64'(stall_count), 64'(e.stall));
        chk({tag, " fwd_a_count"}, 64'(fwd_a_count), 64'(e.fa));
        chk({tag, " fwd_b_count"}, 64'(fwd_b_count), 64'(e.fb));
        chk({tag, " stall_error"}, 64'(stall_error), 64'(e.err));
    endtask

    function automatic exp_t zero_state();
        exp_t z;
        z.a = '0; z.b = '0; z.ctrl = '0; z.dest = '0;
        z.rf = 1'b0; z.ld = 1'b0; z.vld = 1'b0;
        z.stall = 0; z.fa = 0; z.fb = 0; z.err = 1'b0;
        return z;
    endfunction

    function automatic logic [DATA_W-1:0] pick(input logic [1:0] s, input logic [4:0] idx,
                                               input logic [DATA_W-1:0] rf);
        if (idx == 5'd0) return '0;
        if (s == 2'd1) return ex_result;
        if (s == 2'd2) return mem_result;
        if (s == 2'd3) return wb_result;
        return rf;
    endfunction

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Watchdog modelled as "consecutive bubble edges since the last load";
    // the error flag latches once that run exceeds MAX_STALL.
    task automatic model_edge();
        if (hold) return;
        if (nop_signal) begin
            m.a = '0; m.b = '0; m.ctrl = '0; m.dest = '0;
            m.rf = 1'b0; m.ld = 1'b0; m.vld = 1'b0;
            m.stall = sat(m.stall);
            streak++;
            if (streak > MAX_STALL) m.err = 1'b1;
        end else begin
            m.a    = pick(pa_selector, id_rs, id_pa);
            m.b    = pick(pb_selector, id_rt, id_pb);
            m.ctrl = id_ctrl;
            m.dest = id_dest;
            m.rf   = id_rf_enable;
            m.ld   = id_load_instruction;
            m.vld  = 1'b1;
            if (pa_selector != 2'd0 && id_rs != 5'd0) m.fa = sat(m.fa);
            if (pb_selector != 2'd0 && id_rt != 5'd0) m.fb = sat(m.fb);
            streak = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        model_edge();
        sbq.push_back(m);
        @(negedge clk);
    endtask

    task automatic rand_data();
        id_pa       = $urandom;
        id_pb       = $urandom;
        ex_result   = $urandom;
        mem_result  = $urandom;
        wb_result   = $urandom;
        id_ctrl     = CTRL_W'($urandom);
        id_dest     = 5'($urandom);
        id_rs       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        id_rt       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pa_selector = 2'($urandom);
        pb_selector = 2'($urandom);
        id_rf_enable        = 1'($urandom);
        id_load_instruction = 1'($urandom);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        m = zero_state();
        streak = 0;
        compare(m, tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            compare(e, "sb");
        end
    end

    int burst;

    initial begin
        m = zero_state();
        streak = 0;
        burst = 0;
        rand_data();
        id_rs = 5'd7; id_rt = 5'd9;
        nop_signal = 1'b0;
        hold = 1'b0;
        #1;
        compare(m, "por");
        @(negedge clk);
        reset_n = 1'b1;

        // Fill the stage with non-zero state, then reset mid-cycle.
        repeat (3) begin
            rand_data();
            id_rs = 5'd4; id_rt = 5'd8; pa_selector = 2'd1; pb_selector = 2'd3;
            tick();
        end
        hold = 1'b1; nop_signal = 1'b1;
        do_reset("rst_busy");
        hold = 1'b0; nop_signal = 1'b0;

        // First load after reset.
        id_pa = 32'h11; id_rs = 5'd3; pa_selector = 2'b00;
        tick();

        // Forward sweep.
        id_rs = 5'd5; id_rt = 5'd6;
        ex_result = 32'hA; mem_result = 32'hB; wb_result = 32'hC;
        pb_selector = 2'b00;
        for (int s = 1; s < 4; s++) begin
            pa_selector = 2'(s);
            tick();
        end
        pb_selector = 2'b10;
        tick();

        // $0 override.
        id_rs = 5'd0; pa_selector = 2'b01; ex_result = 32'hDEAD;
        tick();

        // Single load-use bubble, then resume.
        nop_signal = 1'b1;
        tick();
        nop_signal = 1'b0; id_rs = 5'd2;
        tick();

        // hold together with nop for two cycles.
        hold = 1'b1; nop_signal = 1'b1; rand_data();
        tick();
        tick();
        hold = 1'b0; nop_signal = 1'b0;
        tick();

        // Three bubbles stay within tolerance, fourth trips the watchdog.
        nop_signal = 1'b1;
        repeat (3) tick();
        chk("wd_within_limit", 64'(stall_error), 64'd0);
        tick();
        chk("wd_tripped", 64'(stall_error), 64'd1);
        nop_signal = 1'b0; rand_data();
        tick();
        chk("wd_sticky_after_load", 64'(stall_error), 64'd1);
        do_reset("rst_clears_error");

        // Reset during a stall run, then a full run must still be tolerated.
        nop_signal = 1'b1;
        repeat (2) tick();
        do_reset("rst_mid_stall");
        repeat (3) tick();
        nop_signal = 1'b0;
        tick();
        chk("wd_run_restarted", 64'(stall_error), 64'd0);

        // Randomised traffic, with a reset in the middle.
        for (int i = 0; i < 600; i++) begin
            rand_data();
            hold = ($urandom_range(0, 7) == 0);
            if (burst > 0) begin
                nop_signal = 1'b1;
                burst--;
            end else if ($urandom_range(0, 5) == 0) begin
                nop_signal = 1'b1;
                burst = $urandom_range(0, 5);
            end else begin
                nop_signal = 1'b0;
            end
            tick();
            if (i == 300) begin
                do_reset("rst_random");
                burst = 0;
            end
        end
        hold = 1'b0; nop_signal = 1'b0;
        repeat (2) @(negedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d expected=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the MIPS core; consumes the hazard/forwarding unit's outputs (pa_selector, pb_selector, nop_signal).
- Selects each source operand from the register file or the EX/MEM/WB result buses, then registers it with the ID control bundle into EX.
- Inserts bubbles on load-use stalls and honours a downstream hold.
- Keeps stall/forward performance counters and a watchdog that flags runaway stalls.

Parameters:
- DATA_W, 32, operand and result width.
- CTRL_W, 16, opaque ALU/memory control bundle width, passed through unchanged.
- CNT_W, 16, performance counter width.
- MAX_STALL, 3, number of consecutive bubble cycles tolerated before stall_error is set.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_pa, id_pb  in  DATA_W  register file read data for rs and rt.
- id_rs, id_rt  in  5  source register indices.
- ex_result, mem_result, wb_result  in  DATA_W  forwarding buses.
- pa_selector, pb_selector  in  2  00 RF, 01 EX, 10 MEM, 11 WB.
- nop_signal  in  1  insert bubble.
- hold  in  1  downstream stall; freeze stage.
- id_ctrl  in  CTRL_W  decoded control.
- id_dest  in  5  destination index.
- id_rf_enable, id_load_instruction  in  1  ID instruction writes RF / is a load.
- ex_a, ex_b  out  DATA_W  registered operands.
- ex_ctrl  out  CTRL_W  registered control.
- ex_destination  out  5  registered destination index.
- ex_rf_enable, ex_load_instruction, ex_valid  out  1  registered flags.
- stall_count, fwd_a_count, fwd_b_count  out  CNT_W  saturating counters.
- stall_error  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, reset_n=0): every output is 0, i.e. the stage holds a bubble. The FSM goes to RUN, run_len to 0.
- Operand mux, combinational: sel_a = pa_selector decoded to id_pa/ex_result/mem_result/wb_result; sel_b is the same for pb_selector.
- $0 override: if id_rs==0 then sel_a=0, and if id_rt==0 then sel_b=0, regardless of selector.
- Register update on each rising edge, in priority order:
  1. hold=1: all ex_* outputs keep their values. nop_signal is ignored, counters are unchanged, FSM and run_len are unchanged.
  2. nop_signal=1: bubble. ex_valid, ex_rf_enable and ex_load_instruction go to 0; ex_ctrl, ex_destination, ex_a and ex_b go to 0.
  3. Otherwise load: ex_a←sel_a, ex_b←sel_b, ex_ctrl←id_ctrl, ex_destination←id_dest, ex_rf_enable←id_rf_enable, ex_load_instruction←id_load_instruction, ex_valid←1.
- Latency: exactly one cycle from ID inputs to ex_* outputs. There is no combinational path from inputs to outputs.
- Counters (incremented only on non-hold edges; each saturates at all-ones and never wraps):
  - stall_count +1 on each bubble edge.
  - fwd_a_count +1 on a load edge with pa_selector≠00 and id_rs≠0.
  - fwd_b_count is the same, using pb_selector and id_rt.
- Watchdog FSM (non-hold edges only):
  - RUN: a bubble edge goes to STALL with run_len=1. A load edge stays in RUN.
  - STALL: a bubble edge increments run_len; when run_len would exceed MAX_STALL, go to ERROR and set stall_error. A load edge returns to RUN with run_len=0.
  - ERROR: stall_error stays 1 until reset. Bubble and load updates to the ex_* outputs continue normally. A load edge sets run_len=0 but the FSM stays in ERROR.
- A load-use stall legally produces exactly one bubble. MAX_STALL=3 leaves margin for multi-cycle units.
- Simultaneous hold and nop: hold wins, so no bubble is recorded. The hazard unit re-evaluates next cycle.
- Reset asserted mid-stall: clears the FSM, counters and stall_error immediately, without waiting for a clock edge.

Decomposition:
- Shared pipeline package holds:
  - forwarding-select constants FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11;
  - watchdog state encoding RUN/STALL/ERROR;
  - REG_ZERO=5'd0.
- One natural sub-module, fwd_operand_mux: a 4:1 select plus the $0 override, instantiated twice (operand A and operand B).

Test Plan:
- Reset with reset_n=0 mid-cycle, all inputs nonzero → all outputs 0 immediately. Release reset, then apply id_pa=0x11, id_rs=3, sel=00 → one edge later ex_a=0x11, ex_valid=1.
- Forward select sweep, id_rs=5 and id_rt=6 with ex_result=0xA, mem_result=0xB, wb_result=0xC: pa_selector=01/10/11 → ex_a=0xA/0xB/0xC; pb_selector=10 → ex_b=0xB; fwd_a_count increments on each load edge.
- $0 override: id_rs=0, pa_selector=01, ex_result=0xDEAD → ex_a=0 and fwd_a_count unchanged.
- Load-use stall, one cycle of nop_signal=1 → that edge gives ex_valid=0, ex_rf_enable=0, stall_count=1; next load edge gives ex_valid=1 and the FSM back in RUN.
- Hold priority: hold=1 together with nop_signal=1 for 2 cycles → ex_* outputs unchanged and stall_count unchanged.
- Watchdog: 4 consecutive bubble edges with MAX_STALL=3 → stall_error=1 after the 4th edge; a following load edge leaves stall_error=1; reset clears it.
